mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int RD_LAT_DEFAULT  = 2;
    localparam int WR_HOLD_DEFAULT = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto a single shared memory port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT  = RD_LAT_DEFAULT,
    parameter int WR_HOLD = WR_HOLD_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_done,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  state_out
);

    // Last value of the access counter before ACCESS is left.
    localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);
    localparam logic [2:0] WR_LAST = 3'(WR_HOLD - 1);

    state_t      state;
    owner_t      owner;
    logic [2:0]  access_cnt;
    logic [1:0]  starve_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;

    logic        fetch_wins;
    logic        data_wins;
    logic [2:0]  access_last;

    // Data has priority unless fetch has already lost twice while waiting.
    always_comb begin
        fetch_wins  = f_req && ((starve_cnt == 2'd2) || !d_req);
        data_wins   = d_req && !fetch_wins;
        access_last = we_q ? WR_LAST : RD_LAST;
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != ST_IDLE);
    assign state_out = state;

    // Transaction FSM; grant, done and mem_wr are registered pulses/levels.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_FETCH;
            access_cnt <= 3'd0;
            starve_cnt <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            mem_wr     <= 1'b0;
            f_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            f_done     <= 1'b0;
            d_done     <= 1'b0;
            f_rdata    <= 32'd0;
            d_rdata    <= 32'd0;
        end else begin
            f_gnt  <= 1'b0;
            d_gnt  <= 1'b0;
            f_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_wins) begin
                        owner      <= OWN_FETCH;
                        addr_q     <= f_addr;
                        wdata_q    <= 32'd0;
                        we_q       <= 1'b0;
                        mem_wr     <= 1'b0;
                        access_cnt <= 3'd0;
                        starve_cnt <= 2'd0;
                        f_gnt      <= 1'b1;
                        state      <= ST_ACCESS;
                    end else if (data_wins) begin
                        owner      <= OWN_DATA;
                        addr_q     <= d_addr;
                        wdata_q    <= d_wdata;
                        we_q       <= d_we;
                        mem_wr     <= d_we;
                        access_cnt <= 3'd0;
                        if (f_req && (starve_cnt != 2'd2)) begin
                            starve_cnt <= starve_cnt + 2'd1;
                        end
                        d_gnt      <= 1'b1;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (access_cnt == access_last) begin
                        mem_wr <= 1'b0;
                        if (we_q) begin
                            d_done <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_CAPTURE;
                        end
                    end else begin
                        access_cnt <= access_cnt + 3'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (owner == OWN_DATA) begin
                        d_rdata <= mem_rdata;
                        d_done  <= 1'b1;
                    end else begin
                        f_rdata <= mem_rdata;
                        f_done  <= 1'b1;
                    end
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_we;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic        f_gnt, f_done, d_gnt, d_done, mem_wr, busy;
    logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  state_out;

    logic        fast_f_req, fast_d_req, fast_d_we;
    logic [31:0] fast_f_addr, fast_d_addr, fast_d_wdata;
    logic        fast_f_gnt, fast_f_done, fast_d_gnt, fast_d_done, fast_mem_wr, fast_busy;
    logic [31:0] fast_f_rdata, fast_d_rdata, fast_mem_addr, fast_mem_wdata, fast_mem_rdata;
    logic [1:0]  fast_state_out;

    always #5 clock = ~clock;

    mem_port_arbiter u_dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .state_out(state_out)
    );

    mem_port_arbiter #(.RD_LAT(1), .WR_HOLD(1)) u_dut_fast (
        .clock(clock), .reset(reset),
        .f_req(fast_f_req), .f_addr(fast_f_addr), .f_gnt(fast_f_gnt), .f_done(fast_f_done),
        .f_rdata(fast_f_rdata),
        .d_req(fast_d_req), .d_we(fast_d_we), .d_addr(fast_d_addr), .d_wdata(fast_d_wdata),
        .d_gnt(fast_d_gnt), .d_done(fast_d_done), .d_rdata(fast_d_rdata),
        .mem_addr(fast_mem_addr), .mem_wr(fast_mem_wr), .mem_wdata(fast_mem_wdata),
        .mem_rdata(fast_mem_rdata),
        .busy(fast_busy), .state_out(fast_state_out)
    );

    // Memory model: data for an address appears RD_LAT cycles after it is presented.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'h8C22_0004 : (a ^ 32'h5A5A_0000);
    endfunction

    logic [31:0] pipe0, pipe1, fast_pipe0;
    always @(posedge clock) begin
        pipe0      <= mem_addr;
        pipe1      <= pipe0;
        fast_pipe0 <= fast_mem_addr;
    end
    assign mem_rdata      = mem_fn(pipe1);
    assign fast_mem_rdata = mem_fn(fast_pipe0);

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_done;
        int          exp_wr;
        logic [31:0] exp_f;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[5];

    int g_cyc[$];
    bit g_dat[$];
    int dn_cyc[$];
    bit dn_dat[$];
    int wr_cnt, wr_bad, both_gnt;

    // Observe ncyc cycles after the cycle in which requests were driven.
    task automatic run_window(input int ncyc, input bit drop_d, input bit drop_f,
                              input logic [31:0] wr_addr);
        g_cyc.delete(); g_dat.delete(); dn_cyc.delete(); dn_dat.delete();
        wr_cnt = 0; wr_bad = 0; both_gnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clock);
            if (f_gnt && d_gnt) both_gnt++;
            if (f_gnt) begin g_cyc.push_back(c); g_dat.push_back(1'b0); if (drop_f) f_req = 1'b0; end
            if (d_gnt) begin g_cyc.push_back(c); g_dat.push_back(1'b1); if (drop_d) d_req = 1'b0; end
            if (f_done) begin dn_cyc.push_back(c); dn_dat.push_back(1'b0); end
            if (d_done) begin dn_cyc.push_back(c); dn_dat.push_back(1'b1); end
            if (mem_wr) begin
                wr_cnt++;
                if (mem_addr !== wr_addr) wr_bad++;
            end
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            f_req = 1'b1; f_addr = v.addr;
        end
        run_window(12, 1'b1, 1'b1, v.addr);
        chk({tag, " gnt_count"}, g_cyc.size(), 1);
        chk({tag, " gnt_cycle"}, (g_cyc.size() > 0) ? g_cyc[0] : -1, 1);
        chk({tag, " gnt_port"}, (g_dat.size() > 0) ? 32'(g_dat[0]) : 32'hFF, 32'(v.is_data));
        chk({tag, " done_count"}, dn_cyc.size(), 1);
        chk({tag, " done_cycle"}, (dn_cyc.size() > 0) ? dn_cyc[0] : -1, v.exp_done);
        chk({tag, " done_port"}, (dn_dat.size() > 0) ? 32'(dn_dat[0]) : 32'hFF, 32'(v.is_data));
        chk({tag, " both_gnt"}, both_gnt, 0);
        chk({tag, " wr_cycles"}, wr_cnt, v.exp_wr);
        chk({tag, " wr_addr_bad"}, wr_bad, 0);
        chk({tag, " f_rdata"}, f_rdata, v.exp_f);
        chk({tag, " d_rdata"}, d_rdata, v.exp_d);
        chk({tag, " busy_after"}, busy, 0);
        if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.wdata);
        d_we = 1'b0;
    endtask

    int exp_sg_cyc[6] = '{1, 6, 11, 16, 21, 26};
    bit exp_sg_dat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int fast_d_done_c, fast_f_done_c;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h10,   32'h0,        4, 0, 32'h8C22_0004, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h40,   32'hDEAD_BEEF, 3, 2, 32'h8C22_0004, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h40,   32'h0,        4, 0, 32'h8C22_0004, 32'h5A5A_0040};
        vecs[3] = '{1'b0, 1'b0, 32'h1000, 32'h0,        4, 0, 32'h5A5A_1000, 32'h5A5A_0040};
        vecs[4] = '{1'b1, 1'b1, 32'h80,   32'h1234_5678, 3, 2, 32'h5A5A_1000, 32'h5A5A_0040};

        reset = 1'b0;
        f_req = 0; d_req = 0; d_we = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
        fast_f_req = 0; fast_d_req = 0; fast_d_we = 0;
        fast_f_addr = 0; fast_d_addr = 0; fast_d_wdata = 0;
        repeat (3) @(negedge clock);
        chk("rst state_out", state_out, 0);
        chk("rst busy", busy, 0);
        chk("rst f_gnt", f_gnt, 0);
        chk("rst d_gnt", d_gnt, 0);
        chk("rst f_done", f_done, 0);
        chk("rst d_done", d_done, 0);
        chk("rst mem_wr", mem_wr, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst f_rdata", f_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 5; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Contention: data wins, fetch granted right after data completes.
        d_req = 1; d_we = 0; d_addr = 32'h44; f_req = 1; f_addr = 32'h10;
        run_window(14, 1'b1, 1'b1, 32'h0);
        chk("cont gnt_count", g_cyc.size(), 2);
        chk("cont first_port", (g_dat.size() > 0) ? 32'(g_dat[0]) : 32'hFF, 1);
        chk("cont first_cyc", (g_cyc.size() > 0) ? g_cyc[0] : -1, 1);
        chk("cont second_port", (g_dat.size() > 1) ? 32'(g_dat[1]) : 32'hFF, 0);
        chk("cont second_cyc", (g_cyc.size() > 1) ? g_cyc[1] : -1, 6);
        chk("cont d_done_cyc", (dn_cyc.size() > 0) ? dn_cyc[0] : -1, 4);
        chk("cont f_done_cyc", (dn_cyc.size() > 1) ? dn_cyc[1] : -1, 9);
        chk("cont both_gnt", both_gnt, 0);
        chk("cont d_rdata", d_rdata, 32'h5A5A_0044);
        chk("cont f_rdata", f_rdata, 32'h8C22_0004);

        // Starvation: both held, grant pattern D D F repeats.
        d_req = 1; d_we = 0; d_addr = 32'h48; f_req = 1; f_addr = 32'h10;
        run_window(28, 1'b0, 1'b0, 32'h0);
        chk("starve gnt_count", g_cyc.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("starve gnt%0d_cyc", k), (g_cyc.size() > k) ? g_cyc[k] : -1, exp_sg_cyc[k]);
            chk($sformatf("starve gnt%0d_port", k), (g_dat.size() > k) ? 32'(g_dat[k]) : 32'hFF,
                32'(exp_sg_dat[k]));
        end
        d_req = 0; f_req = 0;
        run_window(8, 1'b0, 1'b0, 32'h0);
        chk("starve drained", busy, 0);

        // Reset during ACCESS aborts the read without a done pulse.
        f_req = 1; f_addr = 32'h20;
        @(negedge clock);
        f_req = 0;
        @(negedge clock);
        chk("abort in_access", state_out, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("abort state_out", state_out, 0);
        chk("abort busy", busy, 0);
        chk("abort gnt", {f_gnt, d_gnt}, 0);
        chk("abort done", {f_done, d_done}, 0);
        chk("abort mem_wr", mem_wr, 0);
        chk("abort f_rdata", f_rdata, 0);
        chk("abort d_rdata", d_rdata, 0);
        reset = 1'b1;
        run_window(8, 1'b1, 1'b1, 32'h0);
        chk("abort no_done", dn_cyc.size(), 0);
        chk("abort no_gnt", g_cyc.size(), 0);
        apply_vec(vecs[0], "post_abort");

        // Short-latency build: load then fetch back to back.
        fast_d_req = 1; fast_d_we = 0; fast_d_addr = 32'h44;
        fast_f_req = 1; fast_f_addr = 32'h10;
        fast_d_done_c = -1; fast_f_done_c = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (fast_d_gnt) fast_d_req = 0;
            if (fast_f_gnt) fast_f_req = 0;
            if (fast_d_done && fast_d_done_c < 0) fast_d_done_c = c;
            if (fast_f_done && fast_f_done_c < 0) fast_f_done_c = c;
        end
        chk("fast d_done_cyc", fast_d_done_c, 3);
        chk("fast f_done_cyc", fast_f_done_c, 7);
        chk("fast d_rdata", fast_d_rdata, 32'h5A5A_0044);
        chk("fast f_rdata", fast_f_rdata, 32'h8C22_0004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
